// File: rtl/ahb_input_stage_hold_if.sv
// Bus bundle between an AHB master (plus its output-stage partner) and
// ahb_input_stage_hold. The slave modport is the input stage's view; the
// master modport is the view of whatever drives the master side and models
// the output stage.
interface ahb_input_stage_hold_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MASTER_W = 4
);
  // master side
  logic                HSELS;
  logic [ADDR_W-1:0]   HADDRS;
  logic [1:0]          HTRANSS;
  logic                HWRITES;
  logic [2:0]          HSIZES;
  logic [2:0]          HBURSTS;
  logic [3:0]          HPROTS;
  logic [MASTER_W-1:0] HMASTERS;
  logic                HMASTLOCKS;
  logic [DATA_W-1:0]   HWDATAS;
  logic                HREADYS;
  logic                dec_hit;
  logic                HREADYOUTS;
  logic [1:0]          HRESPS;
  logic [DATA_W-1:0]   HRDATAS;
  // output-stage side
  logic                sel_ip;
  logic [ADDR_W-1:0]   addr_ip;
  logic [1:0]          trans_ip;
  logic                write_ip;
  logic [2:0]          size_ip;
  logic [2:0]          burst_ip;
  logic [3:0]          prot_ip;
  logic [MASTER_W-1:0] master_ip;
  logic                mastlock_ip;
  logic [DATA_W-1:0]   wdata_ip;
  logic                held_tran_ip;
  logic                active_ip;
  logic                readyout_ip;
  logic [1:0]          resp_ip;
  logic [DATA_W-1:0]   rdata_ip;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTERS, HMASTLOCKS, HWDATAS, HREADYS, dec_hit,
           active_ip, readyout_ip, resp_ip, rdata_ip,
    output HREADYOUTS, HRESPS, HRDATAS,
           sel_ip, addr_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip,
           master_ip, mastlock_ip, wdata_ip, held_tran_ip
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTERS, HMASTLOCKS, HWDATAS, HREADYS, dec_hit,
           active_ip, readyout_ip, resp_ip, rdata_ip,
    input  HREADYOUTS, HRESPS, HRDATAS,
           sel_ip, addr_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip,
           master_ip, mastlock_ip, wdata_ip, held_tran_ip
  );
endinterface

// File: rtl/ahb_input_stage_hold.sv
// AHB bus-matrix input stage. Passes address phases straight to the output
// stage when this port is granted, otherwise parks them in a hold register
// and stalls the master until the grant arrives.
// Optional macro DEFAULT_SLAVE_EN: transfers with dec_hit=0 get a two-cycle
// ERROR response locally instead of being forwarded.
module ahb_input_stage_hold #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MASTER_W = 4
) (
  input logic                   HCLK,
  input logic                   HRESET,
  ahb_input_stage_hold_if.slave bus
);
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HOLD = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]          state, state_nxt;
  logic                hold_valid;
  logic                h_sel;
  logic [ADDR_W-1:0]   h_addr;
  logic [1:0]          h_trans;
  logic                h_write;
  logic [2:0]          h_size;
  logic [2:0]          h_burst;
  logic [3:0]          h_prot;
  logic [MASTER_W-1:0] h_master;
  logic                h_mastlock;

  logic xfer, hit, miss, good, accept, capture, release_hold;

  // Only NONSEQ/SEQ with the master-level HREADY high start a transfer.
  assign xfer = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;

`ifdef DEFAULT_SLAVE_EN
  assign hit = bus.dec_hit;
`else
  logic unused_dec_hit;
  assign unused_dec_hit = bus.dec_hit;
  assign hit = 1'b1;
`endif

  assign miss = xfer & ~hit;
  assign good = xfer & hit;

  // A new address phase is taken whenever no earlier transfer is pending.
  assign accept       = (state == ST_IDLE) | (state == ST_ERR2) |
                        ((state == ST_DATA) & bus.readyout_ip);
  assign capture      = accept & good & ~bus.active_ip;
  assign release_hold = (state == ST_HOLD) & bus.active_ip & bus.readyout_ip;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD: if (release_hold) state_nxt = ST_DATA;
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        if (accept) begin
          if (miss)      state_nxt = ST_ERR1;
          else if (good) state_nxt = bus.active_ip ? ST_DATA : ST_HOLD;
          else           state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Hold register: loads on an ungranted transfer, drains on grant+ready.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hold_valid <= 1'b0;
      h_sel      <= 1'b0;
      h_addr     <= '0;
      h_trans    <= 2'b00;
      h_write    <= 1'b0;
      h_size     <= 3'b000;
      h_burst    <= 3'b000;
      h_prot     <= 4'b0000;
      h_master   <= '0;
      h_mastlock <= 1'b0;
    end else if (capture) begin
      hold_valid <= 1'b1;
      h_sel      <= bus.HSELS;
      h_addr     <= bus.HADDRS;
      h_trans    <= bus.HTRANSS;
      h_write    <= bus.HWRITES;
      h_size     <= bus.HSIZES;
      h_burst    <= bus.HBURSTS;
      h_prot     <= bus.HPROTS;
      h_master   <= bus.HMASTERS;
      h_mastlock <= bus.HMASTLOCKS;
    end else if (release_hold) begin
      hold_valid <= 1'b0;
    end
  end

  // Request set: held copy while waiting, otherwise the live address phase.
  // A decode miss is masked so the output stage never sees it.
  assign bus.held_tran_ip = hold_valid | good;
  assign bus.sel_ip       = hold_valid ? h_sel      : (bus.HSELS & ~miss);
  assign bus.trans_ip     = hold_valid ? h_trans    : (miss ? 2'b00 : bus.HTRANSS);
  assign bus.addr_ip      = hold_valid ? h_addr     : bus.HADDRS;
  assign bus.write_ip     = hold_valid ? h_write    : bus.HWRITES;
  assign bus.size_ip      = hold_valid ? h_size     : bus.HSIZES;
  assign bus.burst_ip     = hold_valid ? h_burst    : bus.HBURSTS;
  assign bus.prot_ip      = hold_valid ? h_prot     : bus.HPROTS;
  assign bus.master_ip    = hold_valid ? h_master   : bus.HMASTERS;
  assign bus.mastlock_ip  = hold_valid ? h_mastlock : bus.HMASTLOCKS;
  assign bus.wdata_ip     = bus.HWDATAS;
  assign bus.HRDATAS      = bus.rdata_ip;

  // Master-facing ready/response per state.
  always_comb begin
    bus.HREADYOUTS = 1'b1;
    bus.HRESPS     = 2'b00;
    case (state)
      ST_HOLD: bus.HREADYOUTS = 1'b0;
      ST_DATA: begin
        bus.HREADYOUTS = bus.readyout_ip;
        bus.HRESPS     = bus.resp_ip;
      end
      ST_ERR1: begin
        bus.HREADYOUTS = 1'b0;
        bus.HRESPS     = 2'b01;
      end
      ST_ERR2: bus.HRESPS = 2'b01;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ahb_input_stage_hold.sv
// Bench for ahb_input_stage_hold: directed scenarios then random traffic.
// Expected outputs come from a transaction-level model (pending request,
// data-phase flag, error countdown) and are queued for a negedge monitor.
module tb_ahb_input_stage_hold;
  localparam int ADDR_W = 32, DATA_W = 32, MASTER_W = 4;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_input_stage_hold_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASTER_W(MASTER_W)) bus ();

  ahb_input_stage_hold #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASTER_W(MASTER_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );

  typedef struct packed {
    logic        ready;
    logic [1:0]  resp;
    logic        held;
    logic [50:0] req;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;

  // model: one parked request, a data phase in flight, error cycles left
  bit          m_pend, m_busy;
  int          m_err;
  logic [50:0] m_preq;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    n_chk++;
    if (a === x) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, a, x, $time);
  endtask

  function automatic logic [50:0] dut_req();
    return {bus.sel_ip, bus.addr_ip, bus.trans_ip, bus.write_ip, bus.size_ip,
            bus.burst_ip, bus.prot_ip, bus.master_ip, bus.mastlock_ip};
  endfunction

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge HCLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("hreadyout", {63'd0, bus.HREADYOUTS}, {63'd0, e.ready});
      chk("hresp", {62'd0, bus.HRESPS}, {62'd0, e.resp});
      chk("held_tran", {63'd0, bus.held_tran_ip}, {63'd0, e.held});
      chk("request", {13'd0, dut_req()}, {13'd0, e.req});
      chk("data", {bus.HRDATAS, bus.wdata_ip}, {e.rdata, e.wdata});
    end
  end

  task automatic idle_in();
    bus.HSELS = 1'b0; bus.HTRANSS = 2'b00; bus.HADDRS = '0; bus.HWRITES = 1'b0;
    bus.HSIZES = 3'd2; bus.HBURSTS = 3'd0; bus.HPROTS = 4'd3; bus.HMASTERS = 4'd1;
    bus.HMASTLOCKS = 1'b0; bus.HWDATAS = '0; bus.dec_hit = 1'b1;
    bus.active_ip = 1'b1; bus.readyout_ip = 1'b1; bus.resp_ip = 2'b00; bus.rdata_ip = '0;
  endtask

  task automatic nonseq(input logic [31:0] a, input bit act);
    bus.HSELS = 1'b1; bus.HTRANSS = 2'b10; bus.HADDRS = a; bus.active_ip = act;
  endtask

  // One clock: settle HREADYS, predict, queue, advance model at the edge.
  task automatic step(input bit force_rdy = 1'b0, input bit rdy_val = 1'b0);
    exp_t e;
    bit x, hitb, missb, n_pend, n_busy;
    int n_err;
    logic [50:0] live, n_preq;
    if (HRESET) begin m_pend = 0; m_busy = 0; m_err = 0; m_preq = '0; end
    if (m_err == 2)      begin e.ready = 1'b0; e.resp = 2'b01; end
    else if (m_err == 1) begin e.ready = 1'b1; e.resp = 2'b01; end
    else if (m_pend)     begin e.ready = 1'b0; e.resp = 2'b00; end
    else if (m_busy)     begin e.ready = bus.readyout_ip; e.resp = bus.resp_ip; end
    else                 begin e.ready = 1'b1; e.resp = 2'b00; end
    bus.HREADYS = force_rdy ? rdy_val : e.ready;
    x = bus.HSELS && bus.HTRANSS[1] && bus.HREADYS;
`ifdef DEFAULT_SLAVE_EN
    hitb = bus.dec_hit;
`else
    hitb = 1'b1;
`endif
    missb = x && !hitb;
    live = {bus.HSELS & ~missb, bus.HADDRS, missb ? 2'b00 : bus.HTRANSS, bus.HWRITES,
            bus.HSIZES, bus.HBURSTS, bus.HPROTS, bus.HMASTERS, bus.HMASTLOCKS};
    e.held  = m_pend || (x && hitb);
    e.req   = m_pend ? m_preq : live;
    e.rdata = bus.rdata_ip;
    e.wdata = bus.HWDATAS;
    q.push_back(e);
    n_pend = m_pend; n_busy = m_busy; n_err = m_err; n_preq = m_preq;
    if (m_pend) begin
      if (bus.active_ip && bus.readyout_ip) begin n_pend = 0; n_busy = 1; end
    end else if (m_err == 2) begin
      n_err = 1;
    end else if (!(m_busy && !bus.readyout_ip)) begin
      n_err = 0; n_busy = 0;
      if (missb) n_err = 2;
      else if (x) begin
        if (bus.active_ip) n_busy = 1;
        else begin n_pend = 1; n_preq = live; end
      end
    end
    @(posedge HCLK);
    if (!HRESET) begin m_pend = n_pend; m_busy = n_busy; m_err = n_err; m_preq = n_preq; end
    #1;
  endtask

  initial begin
    idle_in();
    bus.HREADYS = 1'b1;
    @(posedge HCLK); #1;
    step(); step();                         // reset state
    HRESET = 1'b0;
    // granted pass-through, then data phase completes
    nonseq(32'h2000_0010, 1'b1); bus.HWDATAS = 32'hA5A5_0001; step();
    idle_in(); bus.rdata_ip = 32'h1234_5678; step(); step();
    // ungranted: held for three cycles while master address moves
    nonseq(32'h2000_0010, 1'b0); bus.HMASTLOCKS = 1'b1; step();
    idle_in(); bus.active_ip = 1'b0; bus.HSELS = 1'b1; bus.HTRANSS = 2'b10;
    step(); step(); step();
    bus.active_ip = 1'b1; bus.HSELS = 1'b0; bus.HTRANSS = 2'b00; step();
    step(); step();
    // two-cycle ERROR from the slave passes through
    nonseq(32'h0000_0100, 1'b1); step();
    idle_in(); bus.resp_ip = 2'b01; bus.readyout_ip = 1'b0; step();
    bus.readyout_ip = 1'b1; step();
    idle_in(); step();
    // IDLE transfers with select high are ignored
    bus.HSELS = 1'b1; bus.HTRANSS = 2'b00; bus.HADDRS = 32'hDEAD_0000; step(); step(); step();
    // reset while a transfer is held
    idle_in(); nonseq(32'h3000_0040, 1'b0); step();
    idle_in(); bus.active_ip = 1'b0; step();
    HRESET = 1'b1; step(); step();
    HRESET = 1'b0; idle_in(); step();
    // decode miss (error path only with DEFAULT_SLAVE_EN)
    nonseq(32'h4000_0000, 1'b1); bus.dec_hit = 1'b0; step();
    idle_in(); step(); step();
    nonseq(32'h4000_0004, 1'b0); bus.dec_hit = 1'b0; step();
    idle_in(); step(); step(); step();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.HSELS = ($urandom % 4) != 0;
      bus.HTRANSS = 2'($urandom);
      bus.HADDRS = $urandom;
      bus.HWRITES = 1'($urandom);
      bus.HSIZES = 3'($urandom);
      bus.HBURSTS = 3'($urandom);
      bus.HPROTS = 4'($urandom);
      bus.HMASTERS = 4'($urandom);
      bus.HMASTLOCKS = 1'($urandom);
      bus.HWDATAS = $urandom;
      bus.dec_hit = ($urandom % 5) != 0;
      bus.active_ip = ($urandom % 3) != 0;
      bus.readyout_ip = ($urandom % 4) != 0;
      bus.resp_ip = (($urandom % 6) == 0) ? 2'b01 : 2'b00;
      bus.rdata_ip = $urandom;
      if (($urandom % 10) == 0) step(1'b1, 1'($urandom));
      else step();
    end
    idle_in();
    step();
    @(negedge HCLK); #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
